seg7_scan: RTL and testbench

Four-digit multiplexed seven-segment display driver for the board's output path. It is the human-facing output counterpart of the key-input conditioning on the same board. The block time-multiplexes a 16-bit hex value, such as the PC or a selected register of the single-cycle CPU, onto common-anode displays. A blanking interval between digits suppresses ghosting, and the value is latched once per frame so the display never shows a torn value.

---
 rtl/seg7_scan_pkg.sv | 18 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan.sv | 110 +++++++++++
 tb/tb_seg7_scan.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared encodings and constants for the four-digit seven-segment scanner.
package seg7_scan_pkg;

  typedef enum logic {
    PhBlank = 1'b0,
    PhShow  = 1'b1
  } phase_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode display driver with per-frame value latch,
// inter-digit blanking and optional leading-zero blanking.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 24'd50_000,
  parameter int unsigned BLANK_TICKS = 24'd1_000,
  parameter int unsigned NBITS       = 24,
  parameter bit          LZB         = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        en_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam logic [NBITS-1:0] BlankLast = NBITS'(BLANK_TICKS - 1);
  localparam logic [NBITS-1:0] DigitLast = NBITS'(DIGIT_TICKS - 1);

  phase_e           phase_q, phase_d;
  logic [1:0]       dig_q, dig_d;
  logic [NBITS-1:0] cnt_q, cnt_d;
  logic [15:0]      sval_q, sval_d;
  logic [3:0]       sdp_q, sdp_d;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;
  logic             latch;
  logic             lz_blank;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg;

  seg7_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
    phase_d = phase_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q + NBITS'(1);
    latch   = (phase_q == PhBlank) && (dig_q == 2'd0) && (cnt_q == '0);
    sval_d  = latch ? value_i : sval_q;
    sdp_d   = latch ? dp_i : sdp_q;

    unique case (phase_q)
      PhBlank: begin
        if (cnt_q == BlankLast) begin
          phase_d = PhShow;
          cnt_d   = '0;
        end
      end
      PhShow: begin
        if (cnt_q == DigitLast) begin
          phase_d = PhBlank;
          cnt_d   = '0;
          dig_d   = dig_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs are derived from next-state so they change on the same edge as phase/digit;
  // this also lets a single-cycle BLANK show a value latched on that very edge.
  always_comb begin
    nibble   = sval_d[{dig_d, 2'b00} +: 4];
    lz_blank = LZB && (dig_d != 2'd0) && ((sval_d >> {dig_d, 2'b00}) == 16'h0000);
    an_d     = AN_OFF;
    seg_d    = SEG_BLANK;
    dp_d     = 1'b1;
    if ((phase_d == PhShow) && en_i) begin
      dp_d = ~sdp_d[dig_d];
      if (!lz_blank) begin
        an_d  = ~(4'b0001 << dig_d);
        seg_d = dec_seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PhBlank;
      dig_q   <= 2'd0;
      cnt_q   <= '0;
      sval_q  <= 16'h0000;
      sdp_q   <= 4'h0;
      an_o    <= AN_OFF;
      seg_o   <= SEG_BLANK;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      phase_q <= phase_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      sval_q  <= sval_d;
      sdp_q   <= sdp_d;
      an_o    <= an_d;
      seg_o   <= seg_d;
      dp_o    <= dp_d;
      frame_o <= latch;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: three parameterisations checked every cycle against a
// position-in-frame reference model, plus table vectors and corner-case sequences.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_i = 16'h1234;
  logic [3:0]  dp_i = 4'h0;
  logic        en_i = 1'b1;
  logic [3:0]  an_w  [3];
  logic [6:0]  seg_w [3];
  logic        dp_w  [3];
  logic        fr_w  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut 0: B=2 D=3; dut 1: same with leading-zero blanking; dut 2: B=1 D=1
  seg7_scan #(.DIGIT_TICKS(3), .BLANK_TICKS(2), .NBITS(4), .LZB(1'b0)) u_a (
    .clk(clk), .rst(rst), .value_i(value_i), .dp_i(dp_i), .en_i(en_i),
    .an_o(an_w[0]), .seg_o(seg_w[0]), .dp_o(dp_w[0]), .frame_o(fr_w[0]));
  seg7_scan #(.DIGIT_TICKS(3), .BLANK_TICKS(2), .NBITS(4), .LZB(1'b1)) u_l (
    .clk(clk), .rst(rst), .value_i(value_i), .dp_i(dp_i), .en_i(en_i),
    .an_o(an_w[1]), .seg_o(seg_w[1]), .dp_o(dp_w[1]), .frame_o(fr_w[1]));
  seg7_scan #(.DIGIT_TICKS(1), .BLANK_TICKS(1), .NBITS(2), .LZB(1'b0)) u_1 (
    .clk(clk), .rst(rst), .value_i(value_i), .dp_i(dp_i), .en_i(en_i),
    .an_o(an_w[2]), .seg_o(seg_w[2]), .dp_o(dp_w[2]), .frame_o(fr_w[2]));

  function automatic int cfg_b(input int k);
    return (k == 2) ? 1 : 2;
  endfunction
  function automatic int cfg_d(input int k);
    return (k == 2) ? 1 : 3;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic int an_idx(input logic [3:0] an);
    case (an)
      4'hE: return 0;
      4'hD: return 1;
      4'hB: return 2;
      4'h7: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h t=%0t", nm, k, got, want, $time);
    end
  endtask

  // Expected outputs for a state given only as a position within the frame period.
  task automatic exp_out(input int k, input int pos, input logic [15:0] sv,
                         input logic [3:0] sd, input logic en, output logic [3:0] an,
                         output logic [6:0] seg, output logic dp);
    int slot, dg;
    logic blank;
    slot = cfg_b(k) + cfg_d(k);
    dg   = pos / slot;
    an = 4'hF; seg = 7'h7F; dp = 1'b1;
    if ((pos % slot) >= cfg_b(k) && en) begin
      dp    = ~sd[dg];
      blank = (k == 1) && (dg > 0) && ((sv >> (4 * dg)) == 16'h0);
      if (!blank) begin
        an  = 4'hF & ~(4'b0001 << dg);
        seg = hex7(4'((sv >> (4 * dg)) & 16'hF));
      end
    end
  endtask

  // Reference model: advanced at each negedge from the inputs sampled at the prior posedge.
  int          mpos [3];
  logic [15:0] msv  [3];
  logic [3:0]  msd  [3];

  initial begin
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed, ef;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          mpos[k] = 0; msv[k] = 16'h0; msd[k] = 4'h0;
          ea = 4'hF; es = 7'h7F; ed = 1'b1; ef = 1'b0;
        end else begin
          ef = (mpos[k] == 0);
          if (ef) begin
            msv[k] = value_i;
            msd[k] = dp_i;
          end
          mpos[k] = (mpos[k] + 1) % (4 * (cfg_b(k) + cfg_d(k)));
          exp_out(k, mpos[k], msv[k], msd[k], en_i, ea, es, ed);
        end
        chk("model_an", k, 32'(an_w[k]), 32'(ea));
        chk("model_seg", k, 32'(seg_w[k]), 32'(es));
        chk("model_dp", k, 32'(dp_w[k]), 32'(ed));
        chk("model_frame", k, 32'(fr_w[k]), 32'(ef));
      end
    end
  end

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [27:0] seg;     // {d3,d2,d1,d0} expected on the plain dut
    logic [3:0]  lzmask;  // digits lit on the leading-zero-blanking dut
  } vec_t;

  vec_t vecs [6];

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (fr_w[0] === 1'b1) ok = 1'b1;
    end
    if (!ok) chk("frame_timeout", 0, 32'd0, 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (an_w[0] === target) ok = 1'b1;
    end
    if (!ok) chk("an_timeout", 0, 32'(an_w[0]), 32'(target));
  endtask

  task automatic run_vec(input vec_t v);
    bit         ok;
    logic [6:0] got [4];
    int         lit [4];
    logic [3:0] dpl, lzl;
    int         dg;
    @(negedge clk); #1;
    value_i = v.value;
    dp_i    = v.dp;
    wait_frame(ok);
    if (ok) begin
      for (int d = 0; d < 4; d++) begin got[d] = 7'h7F; lit[d] = 0; end
      dpl = 4'h0; lzl = 4'h0;
      repeat (19) begin
        @(negedge clk);
        dg = an_idx(an_w[0]);
        if (dg >= 0) begin
          got[dg] = seg_w[0];
          lit[dg]++;
          if (dp_w[0] == 1'b0) dpl[dg] = 1'b1;
        end
        dg = an_idx(an_w[1]);
        if (dg >= 0) lzl[dg] = 1'b1;
      end
      for (int d = 0; d < 4; d++) begin
        chk("vec_seg", d, 32'(got[d]), 32'(v.seg[7*d +: 7]));
        chk("vec_lit_cycles", d, 32'(lit[d]), 32'd3);
      end
      chk("vec_dp", 0, 32'(dpl), 32'(v.dp));
      chk("vec_lzb_mask", 1, 32'(lzl), 32'(v.lzmask));
    end
  endtask

  initial begin
    bit         ok;
    logic [3:0] seq [8];
    vecs[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{16'hABCD, 4'b0001, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111};
    vecs[2] = '{16'h0005, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b0001};
    vecs[3] = '{16'h0000, 4'b1000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0001};
    vecs[4] = '{16'h0F00, 4'b0100, {7'h40, 7'h0E, 7'h40, 7'h40}, 4'b0111};
    vecs[5] = '{16'h00A0, 4'b1011, {7'h40, 7'h40, 7'h08, 7'h40}, 4'b0011};
    seq = '{4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF};

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Mid-frame value change must not tear the frame already latched.
    run_vec(vecs[0]);
    wait_an(4'hD, ok);
    #1 value_i = 16'hABCD;
    wait_an(4'hB, ok);
    chk("torn_d2", 0, 32'(seg_w[0]), 32'h24);
    wait_an(4'h7, ok);
    chk("torn_d3", 0, 32'(seg_w[0]), 32'h79);
    run_vec(vecs[1]);

    // Disable during digit 2: dark on the next edge, frame cadence untouched.
    run_vec(vecs[4]);
    wait_an(4'hB, ok);
    #1 en_i = 1'b0;
    @(negedge clk);
    chk("en_off_an", 0, 32'(an_w[0]), 32'hF);
    chk("en_off_dp", 0, 32'(dp_w[0]), 32'h1);
    repeat (45) @(negedge clk);
    #1 en_i = 1'b1;

    // Reset pulse during digit 3.
    wait_an(4'h7, ok);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_an", 0, 32'(an_w[0]), 32'hF);
    chk("rst_seg", 0, 32'(seg_w[0]), 32'h7F);
    chk("rst_frame", 0, 32'(fr_w[0]), 32'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) chk("rst_frame_after", 0, 32'(fr_w[0]), 32'h1);
      chk("tick1_an_seq", 2, 32'(an_w[2]), 32'(seq[i % 8]));
    end

    // Randomized traffic; the reference model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); #1;
      if ($urandom_range(7) == 0) begin
        value_i = 16'($urandom) & {{4{$urandom_range(1) == 1'b1}}, {4{$urandom_range(1) == 1'b1}},
                                  {4{$urandom_range(1) == 1'b1}}, 4'hF};
        dp_i    = 4'($urandom);
      end
      en_i = ($urandom_range(7) != 0);
      rst  = ($urandom_range(299) == 0);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
